// File: rtl/fifo_dc_reg_pkg.sv
// Shared constants for the dual-clock FIFO register slave: address map,
// interrupt bit positions, threshold reset values and counter width.
`ifndef REG_BUS_AW
`define REG_BUS_AW 8
`endif
`ifndef REG_BUS_DW
`define REG_BUS_DW 32
`endif

package fifo_dc_reg_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_THRESH   = 8'h08;
    localparam logic [7:0] ADDR_INT_STAT = 8'h0C;
    localparam logic [7:0] ADDR_INT_EN   = 8'h10;
    localparam logic [7:0] ADDR_OVF_CNT  = 8'h14;
    localparam logic [7:0] ADDR_UDF_CNT  = 8'h18;

    localparam int INT_OVF = 0;
    localparam int INT_UDF = 1;
    localparam int INT_AFR = 2;

    localparam logic [7:0] AE_THR_RST = 8'd2;
    localparam logic [7:0] AF_THR_RST = 8'd14;

    localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_dc_reg_slave_sat_cnt.sv
// Saturating event counter with clear-on-read; a coincident event
// during the clear leaves the count at 1.
module sat_cnt
    import fifo_dc_reg_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         evt,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= evt ? W'(1) : '0;
        end else if (evt && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fifo_dc_reg_slave.sv
// Register-bus responder for the dual-clock FIFO: control, thresholds,
// interrupts, status view and saturating overflow/underflow counters.
module fifo_dc_reg_slave
    import fifo_dc_reg_pkg::*;
#(
    parameter int REG_AW = `REG_BUS_AW,
    parameter int REG_DW = `REG_BUS_DW,
    parameter int LVL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_req,
    input  logic              reg_wr,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [REG_DW-1:0] reg_wdata,
    output logic [REG_DW-1:0] reg_rdata,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic              ovf_evt,
    input  logic              udf_evt,
    output logic              ctrl_en,
    output logic              ctrl_flush,
    output logic              af_flag,
    output logic              ae_flag,
    output logic              irq
);

    logic             wr, rd;
    logic [7:0]       lvl8;
    logic [7:0]       ae_thr, af_thr;
    logic [2:0]       int_stat, int_en, int_set, int_clr;
    logic             af_prev;
    logic [CNT_W-1:0] ovf_cnt, udf_cnt;
    logic             ovf_clr, udf_clr;
    logic [REG_DW-1:0] rmux;
    logic             unused_wdata;

    assign wr   = reg_req & reg_wr;
    assign rd   = reg_req & ~reg_wr;
    assign lvl8 = 8'(fifo_level);
    assign unused_wdata = ^reg_wdata;

    assign af_flag = (lvl8 >= af_thr);
    assign ae_flag = (lvl8 <= ae_thr);

    assign int_set[INT_OVF] = ovf_evt;
    assign int_set[INT_UDF] = udf_evt;
    assign int_set[INT_AFR] = af_flag & ~af_prev;
    assign int_clr = (wr && reg_addr == REG_AW'(ADDR_INT_STAT)) ? reg_wdata[2:0] : 3'b000;

    assign ovf_clr = rd && (reg_addr == REG_AW'(ADDR_OVF_CNT));
    assign udf_clr = rd && (reg_addr == REG_AW'(ADDR_UDF_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en    <= 1'b0;
            ctrl_flush <= 1'b0;
            ae_thr     <= AE_THR_RST;
            af_thr     <= AF_THR_RST;
            int_en     <= 3'b000;
            int_stat   <= 3'b000;
            af_prev    <= 1'b1;
            irq        <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            ctrl_flush <= wr && (reg_addr == REG_AW'(ADDR_CTRL)) && reg_wdata[1];
            if (wr && reg_addr == REG_AW'(ADDR_CTRL)) begin
                ctrl_en <= reg_wdata[0];
            end
            if (wr && reg_addr == REG_AW'(ADDR_THRESH)) begin
                ae_thr <= reg_wdata[7:0];
                af_thr <= reg_wdata[23:16];
            end
            if (wr && reg_addr == REG_AW'(ADDR_INT_EN)) begin
                int_en <= reg_wdata[2:0];
            end
            // set wins over a simultaneous write-1-to-clear
            int_stat <= (int_stat & ~int_clr) | int_set;
            af_prev  <= af_flag;
            irq      <= |(int_stat & int_en);
            if (rd) begin
                reg_rdata <= rmux;
            end
        end
    end

    always_comb begin
        rmux = '0;
        case (reg_addr)
            REG_AW'(ADDR_CTRL):     rmux[0] = ctrl_en;
            REG_AW'(ADDR_STATUS): begin
                rmux[0]    = fifo_empty;
                rmux[1]    = fifo_full;
                rmux[2]    = ae_flag;
                rmux[3]    = af_flag;
                rmux[15:8] = lvl8;
            end
            REG_AW'(ADDR_THRESH): begin
                rmux[7:0]   = ae_thr;
                rmux[23:16] = af_thr;
            end
            REG_AW'(ADDR_INT_STAT): rmux[2:0] = int_stat;
            REG_AW'(ADDR_INT_EN):   rmux[2:0] = int_en;
            REG_AW'(ADDR_OVF_CNT):  rmux[CNT_W-1:0] = ovf_cnt;
            REG_AW'(ADDR_UDF_CNT):  rmux[CNT_W-1:0] = udf_cnt;
            default:                rmux = '0;
        endcase
    end

    sat_cnt #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (ovf_evt),
        .clr   (ovf_clr),
        .cnt   (ovf_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_udf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (udf_evt),
        .clr   (udf_clr),
        .cnt   (udf_cnt)
    );

endmodule

// File: tb/tb_fifo_dc_reg_slave.sv
// Self-checking bench for fifo_dc_reg_slave: read data goes through an
// expected/observed queue pair, side-band outputs are checked inline.
module tb_fifo_dc_reg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_req = 1'b0;
    logic        reg_wr = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [31:0] reg_wdata = 32'h0;
    logic [31:0] reg_rdata;
    logic [4:0]  fifo_level = 5'd0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        ovf_evt = 1'b0;
    logic        udf_evt = 1'b0;
    logic        ctrl_en, ctrl_flush, af_flag, ae_flag, irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] e, g;

    fifo_dc_reg_slave #(.REG_AW(8), .REG_DW(32), .LVL_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_req    (reg_req),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .ovf_evt    (ovf_evt),
        .udf_evt    (udf_evt),
        .ctrl_en    (ctrl_en),
        .ctrl_flush (ctrl_flush),
        .af_flag    (af_flag),
        .ae_flag    (ae_flag),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        reg_req = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk);
        @(negedge clk);
        reg_req = 1'b0; reg_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] expv);
        exp_q.push_back(expv);
        reg_req = 1'b1; reg_wr = 1'b0; reg_addr = a;
        @(posedge clk);
        @(negedge clk);
        reg_req = 1'b0;
        got_q.push_back(reg_rdata);
    endtask

    task automatic test_reset();
        n_cmp++; if (ctrl_en !== 1'b0) begin n_bad++; $display("FAIL reset ctrl_en: got %b exp 0", ctrl_en); end
        n_cmp++; if (ctrl_flush !== 1'b0) begin n_bad++; $display("FAIL reset ctrl_flush: got %b exp 0", ctrl_flush); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset irq: got %b exp 0", irq); end
        n_cmp++; if (reg_rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata: got %h exp 0", reg_rdata); end
        bus_read(8'h00, 32'h0);
        bus_read(8'h04, 32'h0000_0005);
        bus_read(8'h08, 32'h000E_0002);
        bus_read(8'h0C, 32'h0);
        bus_read(8'h10, 32'h0);
        bus_read(8'h14, 32'h0);
        bus_read(8'h18, 32'h0);
        bus_read(8'h1C, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL reset_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_ctrl();
        bus_write(8'h00, 32'h3);
        n_cmp++; if (ctrl_flush !== 1'b1) begin n_bad++; $display("FAIL ctrl_flush_pulse: got %b exp 1", ctrl_flush); end
        n_cmp++; if (ctrl_en !== 1'b1) begin n_bad++; $display("FAIL ctrl_en_set: got %b exp 1", ctrl_en); end
        @(negedge clk);
        n_cmp++; if (ctrl_flush !== 1'b0) begin n_bad++; $display("FAIL ctrl_flush_end: got %b exp 0", ctrl_flush); end
        bus_read(8'h00, 32'h1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ctrl_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        bus_write(8'h00, 32'h3);
        n_cmp++; if (ctrl_flush !== 1'b1) begin n_bad++; $display("FAIL b2b_flush1: got %b exp 1", ctrl_flush); end
        bus_write(8'h00, 32'h3);
        n_cmp++; if (ctrl_flush !== 1'b1) begin n_bad++; $display("FAIL b2b_flush2: got %b exp 1", ctrl_flush); end
        bus_write(8'h00, 32'h0);
        n_cmp++; if (ctrl_flush !== 1'b0) begin n_bad++; $display("FAIL b2b_flush3: got %b exp 0", ctrl_flush); end
        n_cmp++; if (ctrl_en !== 1'b0) begin n_bad++; $display("FAIL b2b_en_clear: got %b exp 0", ctrl_en); end
        bus_write(8'h00, 32'h1);
        bus_read(8'h00, 32'h1);
        bus_write(8'h10, 32'h5);
        bus_read(8'h10, 32'h5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL b2b_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_thresh_irq();
        bus_write(8'h10, 32'h4);
        bus_write(8'h08, 32'h000C_0003);
        bus_read(8'h08, 32'h000C_0003);
        fifo_empty = 1'b0;
        fifo_level = 5'd3;
        @(negedge clk);
        n_cmp++; if (ae_flag !== 1'b1) begin n_bad++; $display("FAIL ae_at_thr: got %b exp 1", ae_flag); end
        fifo_level = 5'd4;
        @(negedge clk);
        n_cmp++; if (ae_flag !== 1'b0) begin n_bad++; $display("FAIL ae_above_thr: got %b exp 0", ae_flag); end
        fifo_level = 5'd11;
        @(negedge clk);
        n_cmp++; if (af_flag !== 1'b0) begin n_bad++; $display("FAIL af_below_thr: got %b exp 0", af_flag); end
        fifo_level = 5'd12;
        #1;
        n_cmp++; if (af_flag !== 1'b1) begin n_bad++; $display("FAIL af_at_thr: got %b exp 1", af_flag); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b exp 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_af_rise: got %b exp 1", irq); end
        bus_read(8'h04, 32'h0000_0C08);
        bus_read(8'h0C, 32'h4);
        bus_write(8'h0C, 32'h4);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_af_clear: got %b exp 0", irq); end
        bus_read(8'h0C, 32'h0);
        fifo_level = 5'd0;
        fifo_empty = 1'b1;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL thresh_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_counters();
        repeat (3) begin
            ovf_evt = 1'b1; @(negedge clk);
            ovf_evt = 1'b0; @(negedge clk);
        end
        bus_read(8'h14, 32'd3);
        bus_read(8'h14, 32'd0);
        ovf_evt = 1'b1;
        repeat (70000) @(negedge clk);
        ovf_evt = 1'b0;
        bus_read(8'h14, 32'h0000_FFFF);
        bus_read(8'h14, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ovf_cnt_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_w1c_race();
        bus_write(8'h10, 32'h1);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_ovf: got %b exp 1", irq); end
        ovf_evt = 1'b1;
        bus_write(8'h0C, 32'h1);
        ovf_evt = 1'b0;
        bus_read(8'h0C, 32'h1);
        bus_write(8'h0C, 32'h1);
        bus_read(8'h0C, 32'h0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_drop: got %b exp 0", irq); end
        bus_read(8'h14, 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL w1c_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_clr_race();
        repeat (5) begin
            udf_evt = 1'b1; @(negedge clk);
            udf_evt = 1'b0; @(negedge clk);
        end
        udf_evt = 1'b1;
        bus_read(8'h18, 32'd5);
        udf_evt = 1'b0;
        bus_read(8'h18, 32'd1);
        bus_read(8'h18, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL udf_cnt_read: got %h exp %h", g, e); end
        end
    endtask

    task automatic test_reset_mid_access();
        reg_req = 1'b1; reg_wr = 1'b1; reg_addr = 8'h08; reg_wdata = 32'h0010_0001;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reg_req = 1'b0; reg_wr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctrl_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_en: got %b exp 0", ctrl_en); end
        bus_read(8'h08, 32'h000E_0002);
        bus_read(8'h10, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL mid_rst_read: got %h exp %h", g, e); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ctrl();
        test_back_to_back();
        test_thresh_irq();
        test_counters();
        test_w1c_race();
        test_clr_race();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
